luma_2_rgb: RTL and testbench

Duotone colouriser. It is the inverse-direction companion to the RGB-to-luma converter.
- Takes a 24-bit pixel stream, derives an 8-bit luma per pixel and maps it onto a programmable two-colour gradient (shadow colour to highlight colour).
- Sits in the pixel-clock video path, after greyscale conversion and before the DVI/HDMI encoder.
- Fixed 3-cycle pipeline. Video timing signals are delayed alongside the pixel data.
- New colours take effect only at frame start, so a frame never mixes old and new colours (no tearing).

---
 rtl/luma_2_rgb_pkg.sv | 39 +++
 rtl/luma_2_rgb_lerp.sv | 45 ++++
 rtl/luma_2_rgb.sv | 157 +++++++++++++++
 tb/tb_luma_2_rgb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/luma_2_rgb_pkg.sv
// Shared video definitions for the duotone colouriser: pixel layout, luma
// constants, configuration/timing bundles and the frame-start helper.
package luma_2_rgb_pkg;

    localparam int PIX_W   = 24;
    localparam int CH_W    = 8;
    localparam int N_CH    = 3;
    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;

    localparam int SUM_W   = 10;
    localparam int PROD_W  = 20;
    localparam int W_W     = 9;

    localparam int LUMA_MUL   = 683;
    localparam int LUMA_SHIFT = 11;

    typedef struct packed {
        logic             en;
        logic [PIX_W-1:0] lo;
        logic [PIX_W-1:0] hi;
    } duo_cfg_t;

    typedef struct packed {
        logic vde;
        logic hsync;
        logic vsync;
    } vid_timing_t;

    function automatic logic vsync_rise(input logic prev, input logic cur);
        return cur & ~prev;
    endfunction

    function automatic logic [SUM_W-1:0] channel_sum(input logic [PIX_W-1:0] pix);
        return SUM_W'(pix[R_LSB +: CH_W]) + SUM_W'(pix[G_LSB +: CH_W]) + SUM_W'(pix[B_LSB +: CH_W]);
    endfunction

endpackage

// File: rtl/luma_2_rgb_lerp.sv
// Registered single-channel blend between shadow and highlight levels,
// with bypass and blanking folded into the output register.
module duo_lerp8
    import luma_2_rgb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] c_lo,
    input  logic [CH_W-1:0] c_hi,
    input  logic [W_W-1:0]  w,
    input  logic [CH_W-1:0] pix,
    input  logic            en,
    input  logic            vde,
    output logic [CH_W-1:0] result
);

    logic [W_W-1:0]  w_inv;
    logic [16:0]     lo_term;
    logic [16:0]     hi_term;
    logic [16:0]     blend_sum;
    logic [CH_W-1:0] blend;
    logic [CH_W-1:0] result_reg;

    // Weights sum to 256, so the blend never exceeds 255 and needs no clamp.
    assign w_inv     = W_W'(256) - w;
    assign lo_term   = 17'(c_lo) * 17'(w_inv);
    assign hi_term   = 17'(c_hi) * 17'(w);
    assign blend_sum = lo_term + hi_term;
    assign blend     = CH_W'(blend_sum >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
        end else if (!vde) begin
            result_reg <= '0;
        end else if (en) begin
            result_reg <= blend;
        end else begin
            result_reg <= pix;
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/luma_2_rgb.sv
// Duotone colouriser: luma of each pixel selects a point on a programmable
// shadow-to-highlight gradient; colours change only at frame start.
module luma_2_rgb
    import luma_2_rgb_pkg::*;
#(
    parameter bit BYPASS_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] vid_pData_in,
    input  logic             vid_pVDE_in,
    input  logic             vid_pHSync_in,
    input  logic             vid_pVSync_in,
    input  logic             en,
    input  logic [PIX_W-1:0] color_lo,
    input  logic [PIX_W-1:0] color_hi,
    input  logic             cfg_load,
    output logic [PIX_W-1:0] vid_pData_out,
    output logic             vid_pVDE_out,
    output logic             vid_pHSync_out,
    output logic             vid_pVSync_out,
    output logic             cfg_pending
);

    duo_cfg_t    live_cfg;
    duo_cfg_t    pend_cfg_reg, pend_cfg_next;
    duo_cfg_t    app_cfg_reg, app_cfg_next;
    logic        pend_flag_reg, pend_flag_next;
    logic        vs_prev_reg;
    logic        frame_start;
    vid_timing_t live_tim;

    assign live_cfg.en = en;
    assign live_cfg.lo = color_lo;
    assign live_cfg.hi = color_hi;

    assign live_tim.vde   = vid_pVDE_in;
    assign live_tim.hsync = vid_pHSync_in;
    assign live_tim.vsync = vid_pVSync_in;

    assign frame_start = vsync_rise(vs_prev_reg, vid_pVSync_in);

    // A load coinciding with frame start goes straight to the applied set.
    always_comb begin
        app_cfg_next   = app_cfg_reg;
        pend_cfg_next  = pend_cfg_reg;
        pend_flag_next = pend_flag_reg;
        if (frame_start && cfg_load) begin
            app_cfg_next   = live_cfg;
            pend_flag_next = 1'b0;
        end else if (frame_start && pend_flag_reg) begin
            app_cfg_next   = pend_cfg_reg;
            pend_flag_next = 1'b0;
        end else if (cfg_load) begin
            pend_cfg_next  = live_cfg;
            pend_flag_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_reg     <= 1'b0;
            pend_flag_reg   <= 1'b0;
            pend_cfg_reg    <= '0;
            app_cfg_reg.en  <= ~BYPASS_ON_RESET;
            app_cfg_reg.lo  <= '0;
            app_cfg_reg.hi  <= '1;
        end else begin
            vs_prev_reg     <= vid_pVSync_in;
            pend_flag_reg   <= pend_flag_next;
            pend_cfg_reg    <= pend_cfg_next;
            app_cfg_reg     <= app_cfg_next;
        end
    end

    assign cfg_pending = pend_flag_reg;

    // Stage 1: capture pixel with the configuration it will be rendered with.
    logic [PIX_W-1:0] s1_pix_reg;
    duo_cfg_t         s1_cfg_reg;
    vid_timing_t      s1_tim_reg;
    logic [SUM_W-1:0] s1_sum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pix_reg <= '0;
            s1_cfg_reg <= '0;
            s1_tim_reg <= '0;
            s1_sum_reg <= '0;
        end else begin
            s1_pix_reg <= vid_pData_in;
            s1_cfg_reg <= app_cfg_next;
            s1_tim_reg <= live_tim;
            s1_sum_reg <= channel_sum(vid_pData_in);
        end
    end

    // Stage 2: divide by three via reciprocal multiply, then stretch to 0..256.
    logic [PROD_W-1:0] luma_prod;
    logic [CH_W-1:0]   luma;
    logic [W_W-1:0]    w_next;

    assign luma_prod = PROD_W'(s1_sum_reg) * PROD_W'(LUMA_MUL);
    assign luma      = CH_W'(luma_prod >> LUMA_SHIFT);
    assign w_next    = W_W'(luma) + W_W'(luma[CH_W-1]);

    logic [PIX_W-1:0] s2_pix_reg;
    duo_cfg_t         s2_cfg_reg;
    vid_timing_t      s2_tim_reg;
    logic [W_W-1:0]   s2_w_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_pix_reg <= '0;
            s2_cfg_reg <= '0;
            s2_tim_reg <= '0;
            s2_w_reg   <= '0;
        end else begin
            s2_pix_reg <= s1_pix_reg;
            s2_cfg_reg <= s1_cfg_reg;
            s2_tim_reg <= s1_tim_reg;
            s2_w_reg   <= w_next;
        end
    end

    // Stage 3: one blend per channel; each instance registers its own output.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_lerp
            duo_lerp8 u_lerp (
                .clk    (clk),
                .rst    (rst),
                .c_lo   (s2_cfg_reg.lo[gi*CH_W +: CH_W]),
                .c_hi   (s2_cfg_reg.hi[gi*CH_W +: CH_W]),
                .w      (s2_w_reg),
                .pix    (s2_pix_reg[gi*CH_W +: CH_W]),
                .en     (s2_cfg_reg.en),
                .vde    (s2_tim_reg.vde),
                .result (vid_pData_out[gi*CH_W +: CH_W])
            );
        end
    endgenerate

    vid_timing_t s3_tim_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_tim_reg <= '0;
        end else begin
            s3_tim_reg <= s2_tim_reg;
        end
    end

    assign vid_pVDE_out   = s3_tim_reg.vde;
    assign vid_pHSync_out = s3_tim_reg.hsync;
    assign vid_pVSync_out = s3_tim_reg.vsync;

endmodule

// File: tb/tb_luma_2_rgb.sv
// Directed bench for the duotone colouriser: each driven pixel is paired with
// a hand-derived expected output that is compared three cycles later.
module tb_luma_2_rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] vid_pData_in = '0;
    logic        vid_pVDE_in = 1'b0;
    logic        vid_pHSync_in = 1'b0;
    logic        vid_pVSync_in = 1'b0;
    logic        en = 1'b0;
    logic [23:0] color_lo = '0;
    logic [23:0] color_hi = '0;
    logic        cfg_load = 1'b0;
    logic [23:0] vid_pData_out;
    logic        vid_pVDE_out;
    logic        vid_pHSync_out;
    logic        vid_pVSync_out;
    logic        cfg_pending;

    int n_checks = 0;
    int n_pass   = 0;

    logic [26:0] exp_q[$];
    string       tag_q[$];

    luma_2_rgb #(.BYPASS_ON_RESET(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .vid_pData_in   (vid_pData_in),
        .vid_pVDE_in    (vid_pVDE_in),
        .vid_pHSync_in  (vid_pHSync_in),
        .vid_pVSync_in  (vid_pVSync_in),
        .en             (en),
        .color_lo       (color_lo),
        .color_hi       (color_hi),
        .cfg_load       (cfg_load),
        .vid_pData_out  (vid_pData_out),
        .vid_pVDE_out   (vid_pVDE_out),
        .vid_pHSync_out (vid_pHSync_out),
        .vid_pVSync_out (vid_pVSync_out),
        .cfg_pending    (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Grey ramp (lo=000000, hi=FFFFFF) reference: luma by true division.
    function automatic logic [23:0] grey_expect(input int s);
        int l, w, c;
        l = s / 3;
        w = (l >= 128) ? l + 1 : l;
        c = (255 * w) / 256;
        return {c[7:0], c[7:0], c[7:0]};
    endfunction

    task automatic step(input logic [23:0] pix, input logic vde, input logic hs,
                        input logic vs, input logic [23:0] exp_data, input string tag);
        logic [26:0] e;
        logic [26:0] got;
        string       t;
        vid_pData_in  = pix;
        vid_pVDE_in   = vde;
        vid_pHSync_in = hs;
        vid_pVSync_in = vs;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        exp_q.push_back({vde, hs, vs, vde ? exp_data : 24'h000000});
        tag_q.push_back(tag);
        if (exp_q.size() == 3) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {vid_pVDE_out, vid_pHSync_out, vid_pVSync_out, vid_pData_out};
            $display("%s: vde/hs/vs=%b%b%b data=%h exp_data=%h", t,
                     got[26], got[25], got[24], got[23:0], e[23:0]);
            check(t, 32'(got), 32'(e));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "idle");
    endtask

    task automatic load(input logic e_in, input logic [23:0] lo, input logic [23:0] hi);
        en       = e_in;
        color_lo = lo;
        color_hi = hi;
        cfg_load = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with traffic and a stray cfg_load present.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vid_pData_in  = 24'($urandom);
            vid_pVDE_in   = 1'b1;
            vid_pHSync_in = 1'($urandom);
            vid_pVSync_in = 1'($urandom);
            cfg_load      = 1'b1;
            @(posedge clk);
            #1;
            check("reset_outputs", {3'b0, cfg_pending, vid_pVDE_out, vid_pHSync_out,
                  vid_pVSync_out, vid_pData_out}, 32'h0);
        end
        rst      = 1'b0;
        cfg_load = 1'b0;
        exp_q.delete();
        tag_q.delete();

        step(24'h123456, 1'b1, 1'b0, 1'b0, 24'h123456, "bypass_after_reset");
        step(24'hFEDCBA, 1'b1, 1'b1, 1'b0, 24'hFEDCBA, "bypass_hsync");
        idle(2);

        // Colourise.
        load(1'b1, 24'h000080, 24'hFF8000);
        step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "cfg_a");
        check("pend_set_a", 32'(cfg_pending), 32'd1);
        step(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "vs_rise_a");
        check("pend_clr_a", 32'(cfg_pending), 32'd0);
        step(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000080, "col_black");
        step(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 24'hFF8000, "col_white");
        step(24'h808080, 1'b1, 1'b0, 1'b1, 24'h80403F, "col_mid");
        idle(2);

        // Mid-frame load: old colours until the VSync rise.
        load(1'b1, 24'h000000, 24'hFFFFFF);
        step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "cfg_grey");
        check("pend_set_grey", 32'(cfg_pending), 32'd1);
        step(24'h404040, 1'b1, 1'b0, 1'b0, 24'h3F2060, "old_colours");
        check("pend_hold", 32'(cfg_pending), 32'd1);
        step(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "vs_rise_grey");
        check("pend_clr_grey", 32'(cfg_pending), 32'd0);
        step(24'h404040, 1'b1, 1'b0, 1'b1, 24'h3F3F3F, "new_colours");
        idle(2);

        // Two loads before frame start: the second wins.
        load(1'b1, 24'hFF0000, 24'h00FF00);
        step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "cfg_first");
        load(1'b1, 24'h0000FF, 24'hFFFF00);
        step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "cfg_second");
        step(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "vs_rise_last");
        step(24'h000000, 1'b1, 1'b0, 1'b1, 24'h0000FF, "last_write_lo");
        step(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 24'hFFFF00, "last_write_hi");
        idle(2);

        // Load on the VSync rise cycle: applied at once, never pending.
        load(1'b0, 24'h111111, 24'h222222);
        step(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "coll_rise");
        check("coll_pend_0", 32'(cfg_pending), 32'd0);
        step(24'hABCDEF, 1'b1, 1'b0, 1'b1, 24'hABCDEF, "coll_bypass");
        check("coll_pend_1", 32'(cfg_pending), 32'd0);
        idle(2);

        // Luma sweep over every channel sum on the grey ramp.
        load(1'b1, 24'h000000, 24'hFFFFFF);
        step(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, "cfg_sweep");
        step(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "vs_rise_sweep");
        for (int s = 0; s <= 765; s++) begin
            int r, g, b;
            r = (s > 255) ? 255 : s;
            g = ((s - r) > 255) ? 255 : s - r;
            b = s - r - g;
            step({r[7:0], g[7:0], b[7:0]}, 1'b1, 1'b0, 1'b0, grey_expect(s), "luma_sweep");
        end
        step(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, "luma_255");

        // Random timing pattern with a fixed grey ramp.
        for (int i = 0; i < 200; i++) begin
            logic [23:0] p;
            int s;
            p = 24'($urandom);
            s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
            step(p, 1'($urandom), 1'($urandom), 1'($urandom), grey_expect(s), "timing_rand");
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
